sobel_window_fetch: RTL

- Responder for the edge-detection controller's pixel-read commands: start_9_read, start_i_read and start_shift.
- Fetches 3x3 pixel neighbourhoods from image memory through a request/valid read port and holds them as a packed window for the gradient units.
- start_9_read loads a full window. start_shift slides the window one column. start_i_read fetches the new rightmost column.
- Completion is reported back to the controller with single-cycle read_data_done and shift_done strobes.

---
 rtl/sobel_window_fetch_pkg.sv | 17 +
 rtl/sobel_window_fetch_if.sv | 15 +
 rtl/sobel_window_fetch_addr_gen.sv | 19 +
 rtl/sobel_window_fetch.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sobel_window_fetch_pkg.sv
// Shared types and constants for the Sobel 3x3 window fetcher.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    NEXT,
    DONE,
    SHIFT,
    SDONE
  } fetch_state_t;

  localparam int unsigned WIN_DIM  = 3;
  localparam int unsigned FULL_CNT = 9;
  localparam int unsigned COL_CNT  = 3;

endpackage

// File: rtl/sobel_window_fetch_if.sv
// Request/valid image-memory read port used by the window fetcher.
interface sobel_window_fetch_if #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned ADDR_W = 16
) ();

   logic              mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rdata;
   logic              mem_valid;

   modport master (output mem_read, output mem_addr, input mem_rdata, input mem_valid);
   modport slave  (input mem_read, input mem_addr, output mem_rdata, output mem_valid);

endinterface

// File: rtl/sobel_window_fetch_addr_gen.sv
// Pixel address generator: rowbase + row*IMG_W + col + col_off, wrapping at 2^ADDR_W.
module sobel_addr_gen #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IMG_W  = 64
) (
   input  logic [ADDR_W-1:0] rowbase,
   input  logic [ADDR_W-1:0] col,
   input  logic [1:0]        row_off,
   input  logic [1:0]        col_off,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

   always_comb begin
      addr = rowbase + ADDR_W'(row_off) * STRIDE + col + ADDR_W'(col_off);
   end

endmodule

// File: rtl/sobel_window_fetch.sv
// Fetches and shifts a 3x3 pixel window for the Sobel gradient units.
module sobel_window_fetch
   import sobel_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IMG_W  = 64
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start_9_read,
   input  logic                 start_i_read,
   input  logic                 start_shift,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    win_row,
   input  logic [ADDR_W-1:0]    win_col,
   sobel_window_fetch_if.master mem,
   output logic [9*PIX_W-1:0]   window,
   output logic                 read_data_done,
   output logic                 shift_done,
   output logic                 busy
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] rowbase_q, rowbase_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [3:0]        idx_q, idx_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        r_q, r_d;
   logic [1:0]        c_q, c_d;
   logic [PIX_W-1:0]  pix_q [9];
   logic [PIX_W-1:0]  pix_d [9];
   logic [3:0]        pix_idx;
   logic [ADDR_W-1:0] addr;

   assign pix_idx = 4'(r_q) * 4'(WIN_DIM) + 4'(c_q);

   sobel_addr_gen #(
      .ADDR_W (ADDR_W),
      .IMG_W  (IMG_W)
   ) u_addr_gen (
      .rowbase (rowbase_q),
      .col     (col_q),
      .row_off (r_q),
      .col_off (c_q),
      .addr    (addr)
   );

   always_comb begin
      state_d   = state_q;
      rowbase_d = rowbase_q;
      col_d     = col_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      r_d       = r_q;
      c_d       = c_q;
      pix_d     = pix_q;
      unique case (state_q)
         IDLE: begin
            if (start_9_read || (start_i_read && !start_shift)) begin
               rowbase_d = base_addr + win_row * STRIDE;
               col_d     = win_col;
               idx_d     = '0;
               r_d       = '0;
               // An incremental fetch pins the column offset to the rightmost column.
               c_d       = start_9_read ? 2'd0 : 2'(WIN_DIM - 1);
               cnt_d     = start_9_read ? 4'(FULL_CNT) : 4'(COL_CNT);
               state_d   = REQ;
            end else if (start_shift) begin
               state_d = SHIFT;
            end
         end
         REQ: begin
            if (mem.mem_valid) begin
               pix_d[pix_idx] = mem.mem_rdata;
               state_d        = NEXT;
            end
         end
         NEXT: begin
            idx_d = idx_q + 4'd1;
            if (idx_d == cnt_q) begin
               state_d = DONE;
            end else begin
               state_d = REQ;
               if (cnt_q == 4'(COL_CNT) || c_q == 2'(WIN_DIM - 1)) begin
                  r_d = r_q + 2'd1;
                  if (cnt_q != 4'(COL_CNT)) c_d = 2'd0;
               end else begin
                  c_d = c_q + 2'd1;
               end
            end
         end
         DONE:  state_d = IDLE;
         SHIFT: begin
            for (int r = 0; r < 3; r++) begin
               pix_d[r*3]   = pix_q[r*3+1];
               pix_d[r*3+1] = pix_q[r*3+2];
            end
            state_d = SDONE;
         end
         SDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         rowbase_q <= '0;
         col_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         r_q       <= '0;
         c_q       <= '0;
         for (int i = 0; i < 9; i++) pix_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         rowbase_q <= rowbase_d;
         col_q     <= col_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         r_q       <= r_d;
         c_q       <= c_d;
         for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) window[i*PIX_W +: PIX_W] = pix_q[i];
   end

   assign mem.mem_read   = (state_q == REQ);
   assign mem.mem_addr   = addr;
   assign read_data_done = (state_q == DONE);
   assign shift_done     = (state_q == SDONE);
   assign busy           = (state_q != IDLE);

endmodule
